barrel_shifter: RTL and testbench
=================================

# barrel_shifter

Single-cycle 32-bit logarithmic barrel shifter with a registered output. It supports logical left, logical right and arithmetic right shifts by 0–31 positions. It is the shift unit of the datapath ALU, fed from the operand and shift-amount fields and consumed one cycle later by the result mux.

## Interface
Parameters:
- `WIDTH`, 32: data width; must be a power of two ≥ 2.
- `SA_W`, `$clog2(WIDTH)` (5): shift-amount width; derived, not overridden.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst_n`: input, 1 bit. Reset is asynchronous and active-low.
- `valid_in`: input, 1 bit. Operands on `d`/`sa`/`right`/`arith` are valid this cycle.
- `d`: input, `WIDTH` bits. Operand to shift.
- `sa`: input, `SA_W` bits. Shift amount, unsigned, 0..`WIDTH`-1.
- `right`: input, 1 bit. 1 = shift right, 0 = shift left.
- `arith`: input, 1 bit. 1 = arithmetic (sign fill) on right shifts; ignored on left shifts.
- `sh`: output, `WIDTH` bits. Registered shift result.
- `valid_out`: output, 1 bit. `sh` holds the result of an accepted operation.

## Operation
- Left shift (`right`=0): `sh = d << sa`. Vacated LSBs are 0. `arith` has no effect; arithmetic left is identical to logical left.
- Logical right (`right`=1, `arith`=0): `sh = d >> sa`. Vacated MSBs are 0.
- Arithmetic right (`right`=1, `arith`=1): vacated MSBs are copies of `d[WIDTH-1]`. Equivalent to `$signed(d) >>> sa`.
- `sa`=0: `sh = d` for all four `right`/`arith` combinations.
- Core is a log shifter of `SA_W` cascaded stages. Stage k shifts by 2^k when `sa[k]`=1, otherwise passes through. The fill bit is 0, except for arithmetic right where it is `d[WIDTH-1]`, fixed from the original operand at every stage.
- No rotate mode. Bits shifted out are discarded. No carry or overflow flag.
- Out-of-range shifts cannot occur because `sa` is `SA_W` bits wide.

## Timing
- Latency: 1 cycle. On the rising edge where `valid_in`=1, `sh` loads the combinational result and `valid_out` goes to 1.
- On an edge where `valid_in`=0: `sh` holds its previous value and `valid_out` goes to 0.
- Throughput: one operation per cycle. Back-to-back `valid_in` pulses each produce a result on the following cycle. No backpressure.
- Reset: asserting `rst_n`=0 immediately (asynchronously) forces `sh`=0 and `valid_out`=0, including mid-operation. An operation presented in the same cycle as reset is lost.
- First accepted operation after deassertion: `valid_in` sampled on the first rising edge with `rst_n`=1.
- Inputs may change every cycle. Only values at the sampling edge matter. No combinational path from inputs to outputs.

## Structure
- No shared package is required. The direction and mode encodings (`right`, `arith`) are plain bits.
- One sub-module: `barrel_stage`.
  - Parameters: `WIDTH`, `DIST`.
  - Inputs: `in`, `en`, `right`, `fill`.
  - Output: `out`, a shifted or pass-through vector.
  - Instantiated `SA_W` times with `DIST` = 1, 2, 4, 8, 16.
- Top level contains:
  - the fill-bit computation (`fill = right & arith & d[WIDTH-1]`);
  - the stage chain;
  - the output/valid register with asynchronous reset.

## Test plan
All cases use `d`=32'hFF0000FF with `valid_in`=1 and check `sh` one cycle later.
- Shift by 8: left, either `arith` → 32'h0000FF00; logical right → 32'h00FF0000; arithmetic right → 32'hFFFF0000.
- Shift by 4: left → 32'hF0000FF0; logical right → 32'h0FF0000F; arithmetic right → 32'hFFF0000F.
- Shift by 2: left → 32'hFC0003FC; logical right → 32'h3FC0003F; arithmetic right → 32'hFFC0003F.
- Shift by 1: left → 32'hFE0001FE; logical right → 32'h7F80007F; arithmetic right → 32'hFF80007F.
- Shift by 0, all four `right`/`arith` combinations → 32'hFF0000FF.
- Positive operand and reset behaviour:
  - `d`=32'h7F0000FF, `sa`=31 → arithmetic right = 0, logical right = 0, left = 32'h80000000.
  - `valid_in`=0 holds `sh`.
  - `rst_n` pulsed low mid-stream clears `sh`/`valid_out` to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/barrel_shifter_pkg.sv
// Shared constants and helpers for the datapath shift unit.
package barrel_shifter_pkg;

   localparam int unsigned SHIFT_WIDTH = 32;

   // True when w is a power of two and at least 2.
   function automatic bit is_pow2(input int unsigned w);
      return (w >= 2) && ((w & (w - 1)) == 0);
   endfunction

endpackage : barrel_shifter_pkg

// File: rtl/barrel_stage.sv
// One stage of the log shifter. It shifts by DIST when en is set and passes the input through otherwise.
module barrel_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] in,
   input  logic             en,
   input  logic             right,
   input  logic             fill,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;

   // Right shifts take the fill bit in at the top. Left shifts always take zeros in at the bottom.
   assign shl = {in[WIDTH-1-DIST:0], {DIST{1'b0}}};
   assign shr = {{DIST{fill}}, in[WIDTH-1:DIST]};

   assign out = en ? (right ? shr : shl) : in;

endmodule : barrel_stage

// File: rtl/barrel_shifter.sv
// 32-bit logarithmic barrel shifter (left, logical right, arithmetic right) with a registered result.
module barrel_shifter
   import barrel_shifter_pkg::*;
#(
   parameter int unsigned WIDTH = SHIFT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       valid_in,
   input  logic [WIDTH-1:0]           d,
   input  logic [$clog2(WIDTH)-1:0]   sa,
   input  logic                       right,
   input  logic                       arith,
   output logic [WIDTH-1:0]           sh,
   output logic                       valid_out
);

   localparam int unsigned SA_W = $clog2(WIDTH);

   logic             fill;
   logic [WIDTH-1:0] stg [SA_W+1];

   // The sign fill comes from the original operand and stays the same at every stage.
   assign fill   = right & arith & d[WIDTH-1];
   assign stg[0] = d;

   for (genvar k = 0; k < SA_W; k++) begin : g_stage
      barrel_stage #(
         .WIDTH (WIDTH),
         .DIST  (2 ** k)
      ) u_stage (
         .in    (stg[k]),
         .en    (sa[k]),
         .right (right),
         .fill  (fill),
         .out   (stg[k+1])
      );
   end

   // Load the result on accepted operations. Otherwise hold it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh        <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= valid_in;
         if (valid_in) begin
            sh <= stg[SA_W];
         end
      end
   end

endmodule : barrel_shifter

// File: tb/tb_barrel_shifter.sv
// Directed bench for barrel_shifter: table of shift vectors plus hold and async-reset sequences.
module tb_barrel_shifter;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  sa;
      logic        right;
      logic        arith;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        valid_in;
   logic [31:0] d;
   logic [4:0]  sa;
   logic        right;
   logic        arith;
   logic [31:0] sh;
   logic        valid_out;

   int checks;
   int errors;

   barrel_shifter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .d         (d),
      .sa        (sa),
      .right     (right),
      .arith     (arith),
      .sh        (sh),
      .valid_out (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] dd, input logic [4:0] s,
                        input logic r, input logic a);
      valid_in = v;
      d        = dd;
      sa       = s;
      right    = r;
      arith    = a;
   endtask

   vec_t vecs[$];
   logic [31:0] held;

   initial begin
      checks = 0;
      errors = 0;
      // The right and arith fields are given in that order.
      vecs.push_back('{32'hFF0000FF, 5'd8, 1'b0, 1'b0, 32'h0000FF00});
      vecs.push_back('{32'hFF0000FF, 5'd8, 1'b0, 1'b1, 32'h0000FF00});
      vecs.push_back('{32'hFF0000FF, 5'd8, 1'b1, 1'b0, 32'h00FF0000});
      vecs.push_back('{32'hFF0000FF, 5'd8, 1'b1, 1'b1, 32'hFFFF0000});
      vecs.push_back('{32'hFF0000FF, 5'd4, 1'b0, 1'b0, 32'hF0000FF0});
      vecs.push_back('{32'hFF0000FF, 5'd4, 1'b1, 1'b0, 32'h0FF0000F});
      vecs.push_back('{32'hFF0000FF, 5'd4, 1'b1, 1'b1, 32'hFFF0000F});
      vecs.push_back('{32'hFF0000FF, 5'd2, 1'b0, 1'b0, 32'hFC0003FC});
      vecs.push_back('{32'hFF0000FF, 5'd2, 1'b1, 1'b0, 32'h3FC0003F});
      vecs.push_back('{32'hFF0000FF, 5'd2, 1'b1, 1'b1, 32'hFFC0003F});
      vecs.push_back('{32'hFF0000FF, 5'd1, 1'b0, 1'b0, 32'hFE0001FE});
      vecs.push_back('{32'hFF0000FF, 5'd1, 1'b1, 1'b0, 32'h7F80007F});
      vecs.push_back('{32'hFF0000FF, 5'd1, 1'b1, 1'b1, 32'hFF80007F});
      vecs.push_back('{32'hFF0000FF, 5'd0, 1'b0, 1'b0, 32'hFF0000FF});
      vecs.push_back('{32'hFF0000FF, 5'd0, 1'b0, 1'b1, 32'hFF0000FF});
      vecs.push_back('{32'hFF0000FF, 5'd0, 1'b1, 1'b0, 32'hFF0000FF});
      vecs.push_back('{32'hFF0000FF, 5'd0, 1'b1, 1'b1, 32'hFF0000FF});
      vecs.push_back('{32'h7F0000FF, 5'd31, 1'b1, 1'b1, 32'h00000000});
      vecs.push_back('{32'h7F0000FF, 5'd31, 1'b1, 1'b0, 32'h00000000});
      vecs.push_back('{32'h7F0000FF, 5'd31, 1'b0, 1'b0, 32'h80000000});
      vecs.push_back('{32'hFF0000FF, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF});
      vecs.push_back('{32'hFF0000FF, 5'd31, 1'b1, 1'b0, 32'h00000001});
      vecs.push_back('{32'h80000000, 5'd16, 1'b1, 1'b1, 32'hFFFF8000});
      vecs.push_back('{32'h12345678, 5'd12, 1'b0, 1'b1, 32'h45678000});
      vecs.push_back('{32'h12345678, 5'd12, 1'b1, 1'b1, 32'h00012345});

      // An operation presented while reset is asserted is lost.
      rst_n = 1'b0;
      drive(1'b1, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_sh", sh, 32'h0);
      check("reset_valid", 32'(valid_out), 32'h0);
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("idle_valid", 32'(valid_out), 32'h0);

      // The vectors run back to back with valid_in held high.
      for (int i = 0; i < vecs.size(); i++) begin
         drive(1'b1, vecs[i].d, vecs[i].sa, vecs[i].right, vecs[i].arith);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_sh", i), sh, vecs[i].exp);
         check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'h1);
      end

      // With valid_in low, sh holds its value even when the operand fields change.
      held = vecs[vecs.size()-1].exp;
      drive(1'b0, 32'hFFFFFFFF, 5'd3, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_sh", sh, held);
      check("hold_valid", 32'(valid_out), 32'h0);

      // Accept one operation, then pulse reset away from any clock edge.
      drive(1'b1, 32'hFF0000FF, 5'd8, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      check("pre_rst_sh", sh, 32'hFFFF0000);
      check("pre_rst_valid", 32'(valid_out), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_sh", sh, 32'h0);
      check("async_rst_valid", 32'(valid_out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'hFF0000FF, 5'd4, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("post_rst_sh", sh, 32'hF0000FF0);
      check("post_rst_valid", 32'(valid_out), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_barrel_shifter
